// File: rtl/i2c_regs_pkg.sv
// Shared types for the I2C register bank: FSM states and the byte-address decoder.
package i2c_regs_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {IDLE, WAIT, PTR, WRITE, READ} state_e;
  typedef enum logic [1:0] {K_NONE, K_RW, K_RO} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [4:0] idx;
    logic [1:0] bsel;
  } dec_t;

  // Map a byte address onto {bank, register index, byte within register}.
  function automatic dec_t addr_decode(input logic [ADDR_W-1:0] a, input int n_rw,
                                       input int n_ro, input int rbytes, input int ro_base);
    dec_t d;
    int   ai;
    d  = '0;
    ai = int'(a);
    if (ai < n_rw * rbytes) begin
      d.kind = K_RW;
      d.idx  = 5'(ai / rbytes);
      d.bsel = 2'(ai % rbytes);
    end else if (ai >= ro_base && ai < ro_base + n_ro * rbytes) begin
      d.kind = K_RO;
      d.idx  = 5'((ai - ro_base) / rbytes);
      d.bsel = 2'((ai - ro_base) % rbytes);
    end
    return d;
  endfunction

endpackage

// File: rtl/i2c_reg_bank_pulse_timer.sv
// Self-clearing register: holds a committed value for PULSE_LEN clocks, then drops to zero.
module i2c_pulse_timer #(
  parameter int W         = 16,
  parameter int PULSE_LEN = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= '0;
      cnt   <= '0;
    end else if (load) begin
      value <= load_val;
      cnt   <= 8'(PULSE_LEN);
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
      if (cnt == 8'd1) value <= '0;
    end
  end

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C byte engine: pointer FSM, atomic shadowed writes,
// snapshot-coherent multi-byte reads, optional self-clearing registers.
module i2c_reg_bank
  import i2c_regs_pkg::*;
#(
  parameter int                           N_RW         = 16,
  parameter int                           N_RO         = 4,
  parameter int                           REG_BYTES    = 2,
  parameter logic [7:0]                   RO_BASE      = 8'h80,
  parameter logic [N_RW*REG_BYTES*8-1:0]  RESET_VALUES = '0,
  parameter logic [N_RW-1:0]              PULSE_MASK   = '0,
  parameter int                           PULSE_LEN    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          data_vld,
  input  logic                          r_w,
  input  logic [7:0]                    i2c_to_data,
  output logic [7:0]                    data_to_i2c,
  input  logic [N_RO*REG_BYTES*8-1:0]   ro_in,
  output logic [N_RW*REG_BYTES*8-1:0]   regs_out,
  output logic [N_RW-1:0]               upd_strobe
);

  localparam int W  = REG_BYTES * 8;
  localparam int RB = int'(RO_BASE);

  state_e                         state;
  logic [ADDR_W-1:0]              ptr;
  logic [N_RW-1:0][W-1:0]         shadow, reg_q;
  logic [N_RW-1:0][REG_BYTES-1:0] shadow_vld;
  logic [W-1:0]                   snap;
  logic                           snap_vld;
  kind_e                          snap_kind;
  logic [4:0]                     snap_idx;
  logic [7:0]                     dout_q;

  dec_t dec;
  assign dec = addr_decode(ptr, N_RW, N_RO, REG_BYTES, RB);

  // Write path: merge the incoming byte into the addressed shadow word.
  logic                 wr_fire, commit, lower_ok;
  logic [W-1:0]         wr_word;
  logic [REG_BYTES-1:0] vld_word, vld_next;
  logic [N_RW-1:0]      commit_vec;

  always_comb begin
    wr_fire  = data_vld && !start && (state == PTR || state == WRITE) && dec.kind == K_RW;
    wr_word  = '0;
    vld_word = '0;
    for (int i = 0; i < N_RW; i++)
      if (i == int'(dec.idx)) begin
        wr_word  = shadow[i];
        vld_word = shadow_vld[i];
      end
    vld_next = vld_word;
    for (int b = 0; b < REG_BYTES; b++)
      if (b == int'(dec.bsel)) begin
        wr_word[b*8 +: 8] = i2c_to_data;
        vld_next[b]       = 1'b1;
      end
    lower_ok = 1'b1;
    for (int b = 0; b < REG_BYTES - 1; b++)
      if (!vld_word[b]) lower_ok = 1'b0;
    commit = wr_fire && int'(dec.bsel) == REG_BYTES - 1 && lower_ok;
    if (commit) vld_next = '0;
    commit_vec = '0;
    for (int i = 0; i < N_RW; i++)
      if (commit && i == int'(dec.idx)) commit_vec[i] = 1'b1;
  end

  // Read path: byte 0 shows live data; later bytes of the same word come from the snapshot.
  logic [W-1:0] live_word, rd_word;
  logic [7:0]   rd_byte;
  logic         rd_active, snap_hit;

  always_comb begin
    live_word = '0;
    for (int i = 0; i < N_RW; i++)
      if (dec.kind == K_RW && i == int'(dec.idx)) live_word = reg_q[i];
    for (int j = 0; j < N_RO; j++)
      if (dec.kind == K_RO && j == int'(dec.idx)) live_word = ro_in[j*W +: W];
    snap_hit  = snap_vld && snap_kind == dec.kind && snap_idx == dec.idx && dec.bsel != '0;
    rd_word   = snap_hit ? snap : live_word;
    rd_byte   = '0;
    for (int b = 0; b < REG_BYTES; b++)
      if (b == int'(dec.bsel) && dec.kind != K_NONE) rd_byte = rd_word[b*8 +: 8];
    rd_active = r_w && (state == WAIT || state == READ);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      shadow     <= '0;
      shadow_vld <= '0;
      snap       <= '0;
      snap_vld   <= 1'b0;
      snap_kind  <= K_NONE;
      snap_idx   <= '0;
      dout_q     <= '0;
      upd_strobe <= '0;
    end else begin
      upd_strobe <= commit_vec;
      dout_q     <= rd_byte;
      if (rd_active && !start && dec.bsel == '0 && dec.kind != K_NONE) begin
        snap      <= live_word;
        snap_vld  <= 1'b1;
        snap_kind <= dec.kind;
        snap_idx  <= dec.idx;
      end
      if (wr_fire)
        for (int i = 0; i < N_RW; i++)
          if (i == int'(dec.idx)) begin
            shadow[i]     <= wr_word;
            shadow_vld[i] <= vld_next;
          end
      if (start) begin
        // A byte arriving with start is dropped.
        state      <= WAIT;
        shadow_vld <= '0;
        snap_vld   <= 1'b0;
      end else begin
        if (data_vld) begin
          case (state)
            WAIT: begin
              if (r_w) begin
                ptr   <= ptr + 8'd1;
                state <= READ;
              end else begin
                ptr   <= i2c_to_data;
                state <= PTR;
              end
            end
            PTR, WRITE: begin
              ptr   <= ptr + 8'd1;
              state <= WRITE;
            end
            READ:    ptr <= ptr + 8'd1;
            default: ;
          endcase
        end
        // Stop lands after the byte so a completing commit still goes through.
        if (stop) begin
          state      <= IDLE;
          shadow_vld <= '0;
          snap_vld   <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < N_RW; i++) begin : g_reg
    logic [W-1:0] q;
    if (PULSE_MASK[i]) begin : g_pulse
      i2c_pulse_timer #(.W(W), .PULSE_LEN(PULSE_LEN)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (commit_vec[i]),
        .load_val (wr_word),
        .value    (q)
      );
    end else begin : g_plain
      always_ff @(posedge clk) begin
        if (!rst)               q <= RESET_VALUES[i*W +: W];
        else if (commit_vec[i]) q <= wr_word;
      end
    end
    assign reg_q[i] = q;
  end

  assign regs_out    = reg_q;
  assign data_to_i2c = r_w ? dout_q : 8'h00;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank: reset, atomic writes, discard, snapshot reads, pulse regs, wrap.
module tb_i2c_reg_bank;

  localparam logic [63:0] RST_VAL = 64'h0000_0000_3600_0000;

  logic        clk = 1'b0;
  logic        rst, start, stop, data_vld, r_w;
  logic [7:0]  i2c_to_data, data_to_i2c;
  logic [31:0] ro_in;
  logic [63:0] regs_out;
  logic [3:0]  upd_strobe;

  int n_tests = 0;
  int n_fail  = 0;
  int strb_cnt [4];

  i2c_reg_bank #(
    .N_RW(4), .N_RO(2), .REG_BYTES(2), .RO_BASE(8'h10),
    .RESET_VALUES(RST_VAL), .PULSE_MASK(4'b1000), .PULSE_LEN(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .data_vld(data_vld), .r_w(r_w),
    .i2c_to_data(i2c_to_data), .data_to_i2c(data_to_i2c), .ro_in(ro_in),
    .regs_out(regs_out), .upd_strobe(upd_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    for (int i = 0; i < 4; i++) if (upd_strobe[i]) strb_cnt[i]++;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(input logic rw);
    r_w = rw; start = 1'b1; cyc(1); start = 1'b0; cyc(2);
  endtask

  task automatic do_stop();
    stop = 1'b1; cyc(1); stop = 1'b0; cyc(2);
  endtask

  task automatic wr_byte(input logic [7:0] d);
    i2c_to_data = d; data_vld = 1'b1; cyc(1); data_vld = 1'b0; cyc(2);
  endtask

  task automatic rd_byte(output logic [7:0] d);
    d = data_to_i2c; data_vld = 1'b1; cyc(1); data_vld = 1'b0; cyc(2);
  endtask

  task automatic test_reset();
    logic [7:0] b;
    rst = 1'b0; cyc(3);
    n_tests++; if (regs_out !== RST_VAL) begin n_fail++; $display("FAIL reset_regs got %h exp %h", regs_out, RST_VAL); end
    n_tests++; if (upd_strobe !== 4'b0) begin n_fail++; $display("FAIL reset_strobe got %b exp 0000", upd_strobe); end
    n_tests++; if (data_to_i2c !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", data_to_i2c); end
    rst = 1'b1; cyc(1);
    do_start(1'b0); wr_byte(8'h02); do_start(1'b1);
    rd_byte(b);
    n_tests++; if (b !== 8'h00) begin n_fail++; $display("FAIL reset_rd_lo got %h exp 00", b); end
    rd_byte(b);
    n_tests++; if (b !== 8'h36) begin n_fail++; $display("FAIL reset_rd_hi got %h exp 36", b); end
    do_stop();
  endtask

  task automatic test_write();
    int c2, ctot;
    c2 = strb_cnt[2]; ctot = strb_cnt[0] + strb_cnt[1] + strb_cnt[2] + strb_cnt[3];
    do_start(1'b0); wr_byte(8'h04); wr_byte(8'hAD);
    n_tests++; if (regs_out[47:32] !== 16'h0000) begin n_fail++; $display("FAIL write_partial got %h exp 0000", regs_out[47:32]); end
    i2c_to_data = 8'hDE; data_vld = 1'b1; cyc(1);
    n_tests++; if (regs_out[47:32] !== 16'hDEAD) begin n_fail++; $display("FAIL write_commit got %h exp DEAD", regs_out[47:32]); end
    n_tests++; if (upd_strobe !== 4'b0100) begin n_fail++; $display("FAIL write_strobe got %b exp 0100", upd_strobe); end
    data_vld = 1'b0; cyc(1);
    n_tests++; if (upd_strobe !== 4'b0000) begin n_fail++; $display("FAIL write_strobe_end got %b exp 0000", upd_strobe); end
    cyc(1); do_stop();
    n_tests++; if (strb_cnt[2] - c2 !== 1) begin n_fail++; $display("FAIL write_strobe_cnt got %0d exp 1", strb_cnt[2] - c2); end
    n_tests++;
    if (strb_cnt[0] + strb_cnt[1] + strb_cnt[2] + strb_cnt[3] - ctot !== 1) begin
      n_fail++; $display("FAIL write_strobe_total got %0d exp 1", strb_cnt[0] + strb_cnt[1] + strb_cnt[2] + strb_cnt[3] - ctot);
    end
  endtask

  task automatic test_discard();
    logic [7:0] b;
    int c2;
    c2 = strb_cnt[2];
    do_start(1'b0); wr_byte(8'h04); wr_byte(8'h11); do_stop();
    n_tests++; if (regs_out[47:32] !== 16'hDEAD) begin n_fail++; $display("FAIL discard_reg got %h exp DEAD", regs_out[47:32]); end
    n_tests++; if (strb_cnt[2] !== c2) begin n_fail++; $display("FAIL discard_strobe got %0d exp %0d", strb_cnt[2], c2); end
    do_start(1'b0); wr_byte(8'h04); do_start(1'b1);
    rd_byte(b);
    n_tests++; if (b !== 8'hAD) begin n_fail++; $display("FAIL discard_rd_lo got %h exp AD", b); end
    rd_byte(b);
    n_tests++; if (b !== 8'hDE) begin n_fail++; $display("FAIL discard_rd_hi got %h exp DE", b); end
    do_stop();
  endtask

  task automatic test_snapshot();
    logic [7:0] b;
    ro_in = 32'h0000_1234;
    do_start(1'b0); wr_byte(8'h10); do_start(1'b1);
    rd_byte(b);
    n_tests++; if (b !== 8'h34) begin n_fail++; $display("FAIL snap_lo got %h exp 34", b); end
    ro_in = 32'h0000_5678; cyc(2);
    rd_byte(b);
    n_tests++; if (b !== 8'h12) begin n_fail++; $display("FAIL snap_hi got %h exp 12", b); end
    do_stop();
    do_start(1'b0); wr_byte(8'h10); do_start(1'b1);
    rd_byte(b);
    n_tests++; if (b !== 8'h78) begin n_fail++; $display("FAIL snap2_lo got %h exp 78", b); end
    rd_byte(b);
    n_tests++; if (b !== 8'h56) begin n_fail++; $display("FAIL snap2_hi got %h exp 56", b); end
    do_stop();
  endtask

  task automatic test_pulse();
    int c3;
    c3 = strb_cnt[3];
    do_start(1'b0); wr_byte(8'h06); wr_byte(8'hFF);
    i2c_to_data = 8'h00; data_vld = 1'b1; cyc(1);
    n_tests++; if (upd_strobe !== 4'b1000) begin n_fail++; $display("FAIL pulse_strobe got %b exp 1000", upd_strobe); end
    data_vld = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_tests++;
      if (regs_out[63:48] !== 16'h00FF) begin n_fail++; $display("FAIL pulse_hold%0d got %h exp 00FF", k, regs_out[63:48]); end
      cyc(1);
    end
    n_tests++; if (regs_out[63:48] !== 16'h0000) begin n_fail++; $display("FAIL pulse_clear got %h exp 0000", regs_out[63:48]); end
    cyc(3); do_stop();
    n_tests++; if (strb_cnt[3] - c3 !== 1) begin n_fail++; $display("FAIL pulse_strobe_cnt got %0d exp 1", strb_cnt[3] - c3); end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    do_start(1'b0); wr_byte(8'h00); wr_byte(8'h5A); wr_byte(8'hA5); do_stop();
    n_tests++; if (regs_out[15:0] !== 16'hA55A) begin n_fail++; $display("FAIL wrap_reg0 got %h exp A55A", regs_out[15:0]); end
    do_start(1'b0); wr_byte(8'hFE); do_start(1'b1);
    rd_byte(b);
    n_tests++; if (b !== 8'h00) begin n_fail++; $display("FAIL wrap_fe got %h exp 00", b); end
    rd_byte(b);
    n_tests++; if (b !== 8'h00) begin n_fail++; $display("FAIL wrap_ff got %h exp 00", b); end
    rd_byte(b);
    n_tests++; if (b !== 8'h5A) begin n_fail++; $display("FAIL wrap_00 got %h exp 5A", b); end
    n_tests++; if (data_to_i2c !== 8'hA5) begin n_fail++; $display("FAIL wrap_ptr01 got %h exp A5", data_to_i2c); end
    do_stop();
  endtask

  task automatic test_start_stop_edges();
    do_start(1'b0); wr_byte(8'h00); wr_byte(8'h11);
    i2c_to_data = 8'h22; data_vld = 1'b1; stop = 1'b1; cyc(1);
    n_tests++; if (regs_out[15:0] !== 16'h2211) begin n_fail++; $display("FAIL stop_commit got %h exp 2211", regs_out[15:0]); end
    n_tests++; if (upd_strobe !== 4'b0001) begin n_fail++; $display("FAIL stop_strobe got %b exp 0001", upd_strobe); end
    data_vld = 1'b0; stop = 1'b0; cyc(2);
    do_start(1'b0); wr_byte(8'h00); wr_byte(8'h33);
    i2c_to_data = 8'h44; data_vld = 1'b1; start = 1'b1; cyc(1);
    n_tests++; if (regs_out[15:0] !== 16'h2211) begin n_fail++; $display("FAIL start_drop got %h exp 2211", regs_out[15:0]); end
    n_tests++; if (upd_strobe !== 4'b0000) begin n_fail++; $display("FAIL start_drop_strobe got %b exp 0000", upd_strobe); end
    data_vld = 1'b0; start = 1'b0; cyc(2);
    do_stop();
  endtask

  task automatic test_reset_mid();
    do_start(1'b0); wr_byte(8'h02); wr_byte(8'h77);
    rst = 1'b0; cyc(1);
    n_tests++; if (regs_out !== RST_VAL) begin n_fail++; $display("FAIL midreset_regs got %h exp %h", regs_out, RST_VAL); end
    rst = 1'b1; cyc(1);
    do_start(1'b0); wr_byte(8'h03); wr_byte(8'h99); do_stop();
    n_tests++; if (regs_out[31:16] !== 16'h3600) begin n_fail++; $display("FAIL midreset_lost got %h exp 3600", regs_out[31:16]); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; data_vld = 1'b0; r_w = 1'b0;
    i2c_to_data = 8'h00; ro_in = '0;
    foreach (strb_cnt[i]) strb_cnt[i] = 0;
    test_reset();
    test_write();
    test_discard();
    test_snapshot();
    test_pulse();
    test_wrap();
    test_start_stop_edges();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_bank.md
# i2c_reg_bank

Parametrised, fully synchronous register bank that sits behind the I2C slave byte engine, replacing the fixed-map register file.
- Provides N_RW multi-byte read/write registers and N_RO multi-byte read-only status words.
- Pointer auto-increments across both banks.
- Multi-byte writes are atomic, with a per-register update strobe; selected registers can be self-clearing pulses.
- Multi-byte reads are snapshot-coherent.
- All address/FSM logic runs on `clk`; nothing is clocked by I2C strobes.

## Interface
Parameters:
- N_RW, 16: number of read/write registers (1..32).
- N_RO, 4: number of read-only registers (1..16).
- REG_BYTES, 2: bytes per register (1..4), little-endian byte order.
- RO_BASE, 8'h80: byte address of RO register 0; must be ≥ N_RW*REG_BYTES.
- RESET_VALUES, 0: flat N_RW*REG_BYTES*8 vector, register i at bits [i*W +: W], W = REG_BYTES*8.
- PULSE_MASK, 0: N_RW bits; bit i set makes register i self-clearing.
- PULSE_LEN, 3: clocks a pulse register holds its committed value (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  single-cycle pulse on I2C start/repeated start.
- stop  in  1  single-cycle pulse on I2C stop.
- data_vld  in  1  single-cycle pulse, one per transferred data byte.
- r_w  in  1  0 = master write, 1 = master read; stable from start to stop.
- i2c_to_data  in  8  received byte, valid with data_vld.
- data_to_i2c  out  8  byte to transmit; 8'h00 when r_w = 0.
- ro_in  in  N_RO*W  read-only status words, flat.
- regs_out  out  N_RW*W  committed register values, flat.
- upd_strobe  out  N_RW  one-clock pulse per register on commit.

## Operation
- Byte address map:
  - RW register i, byte b is at i*REG_BYTES+b.
  - RO register j, byte b is at RO_BASE+j*REG_BYTES+b.
  - Everything else is unmapped.
- FSM states:
  - IDLE → (start) WAIT.
  - WAIT → (data_vld, r_w=0) PTR: the byte loads the 8-bit pointer. No register write occurs.
  - WAIT → (data_vld, r_w=1) READ: the byte just sent is consumed and the pointer increments.
  - PTR → (data_vld) WRITE.
  - WRITE → (data_vld) WRITE.
  - READ → (data_vld) READ.
  - Any state → (stop) IDLE.
  - Any state → (start) WAIT.
- The pointer persists across transactions. This allows a write-pointer followed by a repeated-start read.
- Pointer behaviour in WRITE/READ: increments by 1 per data_vld and wraps 8'hFF → 8'h00.
- Write path:
  - A byte to RW address (i,b) goes to shadow[i] byte b.
  - Writing byte b = REG_BYTES-1 commits all of shadow[i] to regs_out[i] and pulses upd_strobe[i].
  - Writes to RO or unmapped addresses are ignored.
  - Start or stop clears the shadow-valid flags. A partial multi-byte write is discarded and never committed.
- Read path:
  - Reading byte 0 of any register latches the full word (regs_out or ro_in) into a snapshot.
  - Bytes 1..REG_BYTES-1 of the same register come from the snapshot.
  - A read that begins at byte b > 0 returns live data.
  - Unmapped addresses read 8'h00.
- Pulse registers (PULSE_MASK[i] = 1):
  - After commit, the value holds for PULSE_LEN clocks, then regs_out[i] returns to 0. No upd_strobe is generated on the clear.
  - A new commit during the hold reloads the value and restarts the count.
- Reset values:
  - regs_out = RESET_VALUES, upd_strobe = 0, data_to_i2c = 0.
  - Pointer = 0, state IDLE, pulse counters = 0.
  - RESET_VALUES bits of pulse registers are forced to 0.

## Timing
- Commit latency: regs_out and upd_strobe update on the clk edge after the data_vld cycle of the last byte.
- Read latency: data_to_i2c shows the byte at the current pointer no later than 2 clocks after the data_vld, start or pointer load that changed it. The byte engine must sample it ≥ 2 clocks later.
- Start and data_vld in the same cycle: start wins and the byte is dropped.
- Stop and data_vld in the same cycle: the byte is processed first, then the FSM goes to IDLE. A completing commit still happens.
- Minimum spacing between data_vld pulses is 3 clocks.
- Reset asserted mid-transaction:
  - All state returns to reset values on the next edge.
  - Uncommitted shadows are lost.

## Structure
- Shared package i2c_regs_pkg holds:
  - FSM state enum {IDLE, WAIT, PTR, WRITE, READ};
  - ADDR_W = 8;
  - an address-decode function returning {kind RW/RO/NONE, index, byte}.
- One sub-module, `i2c_pulse_timer`, instantiated per register with PULSE_MASK[i] set. It provides the load/hold/clear counter.

## Test plan
Bench parameters: N_RW=4, REG_BYTES=2, N_RO=2, RO_BASE=8'h10, PULSE_MASK=4'b1000, PULSE_LEN=3, RESET_VALUES reg1=16'h3600.
1. Reset → regs_out reg1 = 16'h3600, others 0; upd_strobe = 0; read from address 0x02 returns 0x00, 0x36.
2. Write pointer 0x04, then bytes 0xAD, 0xDE → reg2 = 16'hDEAD, one-clock upd_strobe[2], exactly once, one clock after the second data_vld.
3. Write pointer 0x04, byte 0x11, then stop → reg2 unchanged, no strobe; a later read of 0x04–0x05 returns the old value.
4. ro_in reg0 = 16'h1234. Read from 0x10; change ro_in to 16'h5678 between bytes → returns 0x34, 0x12 (snapshot); the next read returns 0x78, 0x56.
5. Write 16'h00FF to reg3 (pulse) → regs_out reg3 = 16'h00FF for 3 clocks then 0; upd_strobe[3] pulses once.
6. Pointer 0xFE, read 3 bytes → data from 0xFE, 0xFF, 0x00 all return 8'h00 (unmapped 0xFE/0xFF) except 0x00 = reg0 low byte; pointer ends at 0x01.
